// File: rtl/term_writer_if.sv
// Byte-stream input and character-RAM write/cursor outputs of the terminal writer.
// master: the writer itself; slave: the byte producer / RAM / video side.
interface term_writer_if #(
  parameter int unsigned ADDR_W = 11
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [4:0]        scroll_row;
  logic [4:0]        cur_row;
  logic [6:0]        cur_col;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, scroll_row, cur_row, cur_col
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, scroll_row, cur_row, cur_col
  );
endinterface

// File: rtl/term_writer.sv
// Character stream to 80x25 text buffer writer with ring-buffer scrolling.
// Optional TERM_WRITER_FF_CLEAR_EN: form feed (0x0C) clears the whole screen.
module term_writer #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 25,
  parameter int unsigned ADDR_W = 11
) (
  input logic           clk100,
  input logic           rst,
  term_writer_if.master bus
);
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StClrLine = 2'd1;
`ifdef TERM_WRITER_FF_CLEAR_EN
  localparam logic [1:0] StClrAll  = 2'd2;
`endif
  localparam logic [4:0]        RowLast = 5'(ROWS - 1);
  localparam logic [6:0]        ColLast = 7'(COLS - 1);
  localparam logic [ADDR_W-1:0] ColsA   = ADDR_W'(COLS);

  logic [1:0]        state_q, state_d;
  logic [4:0]        phys_row_q, phys_row_d;
  logic [4:0]        scroll_row_q, scroll_row_d;
  logic [6:0]        col_q, col_d;
  logic [6:0]        clr_col_q, clr_col_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [4:0]        cur_row;
  logic [ADDR_W-1:0] row_base;
  logic [7:0]        tab_col;
  logic              newline;
`ifdef TERM_WRITER_FF_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

  function automatic logic [4:0] inc_row(input logic [4:0] r);
    return (r == RowLast) ? 5'd0 : r + 5'd1;
  endfunction

  always_comb begin
    if (phys_row_q >= scroll_row_q) cur_row = phys_row_q - scroll_row_q;
    else                            cur_row = phys_row_q + 5'(ROWS) - scroll_row_q;
  end

  assign row_base = ADDR_W'(phys_row_q) * ColsA;
  assign tab_col  = {1'b0, col_q | 7'd7} + 8'd1;

  always_comb begin
    state_d      = state_q;
    phys_row_d   = phys_row_q;
    scroll_row_d = scroll_row_q;
    col_d        = col_q;
    clr_col_d    = clr_col_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    newline      = 1'b0;
`ifdef TERM_WRITER_FF_CLEAR_EN
    clr_addr_d   = clr_addr_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base + ADDR_W'(col_q);
            wr_data_d = bus.in_data;
            if (col_q == ColLast) begin
              col_d   = 7'd0;
              newline = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (bus.in_data)
              8'h0A: newline = 1'b1;
              8'h0D: col_d = 7'd0;
              8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
              8'h09: col_d = (tab_col > {1'b0, ColLast}) ? ColLast : tab_col[6:0];
`ifdef TERM_WRITER_FF_CLEAR_EN
              8'h0C: begin
                state_d      = StClrAll;
                clr_addr_d   = '0;
                phys_row_d   = 5'd0;
                scroll_row_d = 5'd0;
                col_d        = 7'd0;
              end
`endif
              default: ;
            endcase
          end
          if (newline) begin
            if (cur_row != RowLast) begin
              phys_row_d = inc_row(phys_row_q);
            end else begin
              // Old top row is recycled as the new bottom row and blanked.
              phys_row_d   = scroll_row_q;
              scroll_row_d = inc_row(scroll_row_q);
              state_d      = StClrLine;
              clr_col_d    = 7'd0;
            end
          end
        end
      end
      StClrLine: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_base + ADDR_W'(clr_col_q);
        wr_data_d = 8'h20;
        if (clr_col_q == ColLast) state_d = StIdle;
        else                      clr_col_d = clr_col_q + 7'd1;
      end
`ifdef TERM_WRITER_FF_CLEAR_EN
      StClrAll: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = 8'h20;
        if (clr_addr_q == ADDR_W'(COLS * ROWS - 1)) state_d = StIdle;
        else                                        clr_addr_d = clr_addr_q + 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q      <= StIdle;
      phys_row_q   <= 5'd0;
      scroll_row_q <= 5'd0;
      col_q        <= 7'd0;
      clr_col_q    <= 7'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
`ifdef TERM_WRITER_FF_CLEAR_EN
      clr_addr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      phys_row_q   <= phys_row_d;
      scroll_row_q <= scroll_row_d;
      col_q        <= col_d;
      clr_col_q    <= clr_col_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
`ifdef TERM_WRITER_FF_CLEAR_EN
      clr_addr_q   <= clr_addr_d;
`endif
    end
  end

  assign bus.in_ready   = (state_q == StIdle) && !rst;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.scroll_row = scroll_row_q;
  assign bus.cur_row    = cur_row;
  assign bus.cur_col    = col_q;
endmodule

// File: tb/tb_term_writer.sv
// Self-checking bench for term_writer: logical-cursor model with timed expected-write queue.
module tb_term_writer;
  localparam int COLS = 80;
  localparam int ROWS = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  term_writer_if #(.ADDR_W(11)) bus_if ();

  term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(11)) dut (
    .clk100 (clk),
    .rst    (rst),
    .bus    (bus_if)
  );

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  m_row, m_col, m_scroll, ready_cyc;
  int  last_addr, last_data, wr_count, last_waits;
  bit  chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: logical cursor row plus scroll offset; physical row derived from them.
  function automatic int phys_now();
    return (m_row + m_scroll) % ROWS;
  endfunction

  task automatic push_wr(input int c, input int a, input int d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic model_newline(input int n);
    if (m_row < ROWS - 1) m_row++;
    else begin
      m_scroll = (m_scroll + 1) % ROWS;
      for (int i = 0; i < COLS; i++) push_wr(n + 2 + i, phys_now() * COLS + i, 32);
      ready_cyc = n + COLS + 1;
    end
  endtask

  task automatic model_byte(input int b, input int n);
    if (b >= 32 && b <= 126) begin
      push_wr(n + 1, phys_now() * COLS + m_col, b);
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_newline(n);
      end else m_col++;
    end else if (b == 10) model_newline(n);
    else if (b == 13) m_col = 0;
    else if (b == 8) begin
      if (m_col > 0) m_col--;
    end else if (b == 9) begin
      m_col = (m_col / 8 + 1) * 8;
      if (m_col > COLS - 1) m_col = COLS - 1;
    end
`ifdef TERM_WRITER_FF_CLEAR_EN
    else if (b == 12) begin
      m_row = 0; m_col = 0; m_scroll = 0;
      for (int i = 0; i < COLS * ROWS; i++) push_wr(n + 2 + i, i, 32);
      ready_cyc = n + COLS * ROWS + 1;
    end
`endif
  endtask

  task automatic compare_cycle();
    bit exp_wr;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missed_write_cycle", cyc, exp_q[0].cyc);
      exp_q.delete(0);
    end
    exp_wr = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("wr_en", int'(bus_if.wr_en), int'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", int'(bus_if.wr_addr), exp_q[0].addr);
      check("wr_data", int'(bus_if.wr_data), exp_q[0].data);
      exp_q.delete(0);
    end
    if (bus_if.wr_en) begin
      last_addr = int'(bus_if.wr_addr);
      last_data = int'(bus_if.wr_data);
      wr_count++;
    end
    check("cur_row", int'(bus_if.cur_row), m_row);
    check("cur_col", int'(bus_if.cur_col), m_col);
    check("scroll_row", int'(bus_if.scroll_row), m_scroll);
    check("in_ready", int'(bus_if.in_ready), int'(cyc >= ready_cyc));
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (chk_en) compare_cycle();
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int b);
    int waits = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'(b);
    while (!bus_if.in_ready && waits < 3000) begin
      @(negedge clk);
      waits++;
    end
    if (!bus_if.in_ready) begin
      check("accept_timeout_waits", waits, 0);
      bus_if.in_valid = 1'b0;
    end else model_byte(b, cyc);
    last_waits = waits;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus_if.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    chk_en = 1'b0;
    @(posedge clk);
    #2;
    check("rst_wr_en", int'(bus_if.wr_en), 0);
    check("rst_wr_addr", int'(bus_if.wr_addr), 0);
    check("rst_wr_data", int'(bus_if.wr_data), 0);
    check("rst_in_ready", int'(bus_if.in_ready), 0);
    check("rst_cur_row", int'(bus_if.cur_row), 0);
    check("rst_cur_col", int'(bus_if.cur_col), 0);
    check("rst_scroll_row", int'(bus_if.scroll_row), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_row = 0; m_col = 0; m_scroll = 0; ready_cyc = 0; wr_count = 0;
    #1;
    check("post_rst_in_ready", int'(bus_if.in_ready), 1);
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
    do_reset();

    // "AB" back to back
    send(8'h41); send(8'h42); idle(2);
    check("ab_cur_col", int'(bus_if.cur_col), 2);
    check("ab_last_addr", last_addr, 1);
    check("ab_last_data", last_data, 8'h42);
    check("ab_writes", wr_count, 2);

    // Cursor edits: CR, BS, TAB
    do_reset();
    repeat (79) send(8'h78);
    check("x79_col", int'(bus_if.cur_col), 79);
    check("x79_last_addr", last_addr, 78);
    send(8'h0D);
    check("cr_col", int'(bus_if.cur_col), 0);
    send(8'h79);
    send(8'h08); send(8'h08);
    check("bs_col", int'(bus_if.cur_col), 0);
    send(8'h09); idle(2);
    check("tab_col", int'(bus_if.cur_col), 8);
    check("y_addr", last_addr, 0);
    check("y_data", last_data, 8'h79);

    // Wrap without scroll
    do_reset();
    repeat (80) send(8'h7A);
    idle(2);
    check("z80_last_addr", last_addr, 79);
    check("z80_cur_row", int'(bus_if.cur_row), 1);
    check("z80_cur_col", int'(bus_if.cur_col), 0);
    check("z80_writes", wr_count, 80);

    // LF on last row scrolls; held byte accepted only after the clear
    do_reset();
    repeat (24) send(8'h0A);
    repeat (5) send(8'h61);
    check("pre_scroll_row", int'(bus_if.cur_row), 24);
    wr_count = 0;
    send(8'h0A);
    send(8'h71);
    check("busy_wait_cycles", last_waits, 80);
    idle(2);
    check("lf_scroll_row", int'(bus_if.scroll_row), 1);
    check("lf_cur_row", int'(bus_if.cur_row), 24);
    check("lf_writes", wr_count, 81);
    check("q_addr", last_addr, 5);

    // Wrap on last row scrolls too
    repeat (74) send(8'h77);
    idle(90);
    check("wrap_scroll_row", int'(bus_if.scroll_row), 2);
    check("wrap_cur_col", int'(bus_if.cur_col), 0);
    check("wrap_clear_last_addr", last_addr, 159);
    check("wrap_clear_last_data", last_data, 8'h20);

    // Reset in the 40th cycle of a line clear
    do_reset();
    repeat (24) send(8'h0A);
    send(8'h0A);
    idle(39);
    do_reset();
    idle(3);
    check("after_abort_writes", wr_count, 0);

    // Form feed
    do_reset();
    send(8'h41); send(8'h42); send(8'h0C);
    send(8'h43);
`ifdef TERM_WRITER_FF_CLEAR_EN
    check("ff_busy_wait", last_waits, 2000);
    idle(2);
    check("ff_writes", wr_count, 2003);
    check("ff_cur_col", int'(bus_if.cur_col), 1);
    check("ff_last_addr", last_addr, 0);
`else
    check("ff_no_wait", last_waits, 0);
    idle(2);
    check("ff_writes", wr_count, 3);
    check("ff_cur_col", int'(bus_if.cur_col), 3);
    check("ff_last_addr", last_addr, 2);
`endif

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
